pipe_stage_fifo: RTL
====================

// Module: pipe_stage_fifo
// PURPOSE
//  Parametrised decoupling buffer placed on any valid/ready link between core stages
//  (IFU->IDU, IDU->EXU, EXU->WBU). It replaces the hard single-beat handshake with a
//  DEPTH-entry in-order queue. It has an optional empty-bypass path, an optional
//  ready-when-full-and-popping path, and a synchronous flush used on branch_taken/trap
//  to drop wrong-path payloads.
// PARAMETERS
//  WIDTH      32  payload bits per entry (pc+instr bundles: 64; decode bundles: wider)
//  DEPTH      2   number of storage entries, >=1, not required to be a power of two
//  BYPASS     0   1: when empty, in_data/in_valid reach the outputs combinationally
//  PIPE_READY 0   1: in_ready stays high when full if out_ready pops this cycle
// PORTS
//  clk        in   1             core clock, single clock domain
//  rst        in   1             synchronous reset, active-high
//  flush      in   1             synchronous flush, discard all held and incoming data
//  in_valid   in   1             producer payload valid
//  in_ready   out  1             buffer can accept this cycle
//  in_data    in   WIDTH         producer payload
//  out_valid  out  1             head payload valid to consumer
//  out_ready  in   1             consumer accepts head this cycle
//  out_data   out  WIDTH         head payload
//  count      out  CW            entries held, CW=$clog2(DEPTH+1)
// BEHAVIOUR
//  - One clock. Reset is synchronous and active-high. All state updates on posedge clk.
//  - Reset: count=0, rd/wr ptr=0. While rst=1, in_ready=0 and out_valid=0.
//    Storage array is not reset.
//  - push = in_valid & in_ready. pop = out_valid & out_ready.
//  - Producer rule: in_data is held stable while in_valid=1 and !in_ready.
//    The buffer never depends on in_valid being dropped.
//  - Consumer rule: out_valid never deasserts without a pop, except on flush or rst.
//    out_data is stable while out_valid=1 and !out_ready.
//  - Latency, BYPASS=0: a push in cycle N makes data visible at out_* in cycle N+1.
//  - Latency, BYPASS=1 and count=0: out_valid=in_valid and out_data=in_data in the
//    same cycle. If out_ready=1, the beat passes through and is not stored.
//    Otherwise it is written and count becomes 1.
//  - in_ready = !flush & !rst & ((count<DEPTH) | (PIPE_READY & out_ready & count==DEPTH)).
//  - out_valid = !flush & !rst & ((count!=0) | (BYPASS & in_valid)).
//  - Simultaneous push and pop with count in 1..DEPTH: count unchanged, both pointers advance.
//  - Full (count==DEPTH) with PIPE_READY=0: in_ready=0 even if out_ready=1.
//  - Pointer wrap: ptr==DEPTH-1 advances to 0. Arithmetic is explicit, not modulo 2^n.
//  - DEPTH=1: behaves as a single staging register. Wrap logic degenerates to ptr=0.
//  - Flush priority: rst > flush > push/pop.
//    - In the flush cycle, in_ready=0 and out_valid=0, so no handshake completes.
//    - Next cycle: count=0, ptrs=0.
//    - flush held multiple cycles keeps the buffer empty.
//  - Flush and rst asserted mid-transfer: the in-flight beat is dropped. The producer
//    must re-present only if it still wants the transfer.
//  - count never exceeds DEPTH and never underflows. Verification asserts both.
//  - No combinational path from out_ready to in_ready unless PIPE_READY=1.
//    No path from in_valid to out_valid unless BYPASS=1.
// STRUCTURE
//  - No new typedefs. CW is a localparam.
//  - Stage payload bundle structs live in the shared common.vh package, packed to WIDTH.
//  - Sub-module pipe_fifo_mem: DEPTH x WIDTH register array with one write port
//    (we, waddr, wdata) and one async read port (raddr -> rdata).
//  - Pointer, count and flush control stay in pipe_stage_fifo.
// TESTING
//  1. Reset then idle, DEPTH=2: in_ready=1, out_valid=0, count=0.
//     Push 0xA, 0xB with out_ready=0 -> count=2, in_ready=0, out_data=0xA.
//  2. Full, DEPTH=2, PIPE_READY=0: out_ready=1, in_valid=1 with 0xC -> pop 0xA,
//     no push, count=1. Next cycle push 0xC -> order at output is 0xB, 0xC.
//  3. Wrap, DEPTH=3: stream 0x1..0x7 with out_ready toggling 1,0,1,0 ->
//     output 0x1..0x7 in order, no loss or duplication, count <=3 always.
//  4. BYPASS=1, empty: in_valid=1 with 0x55, out_ready=1 -> out_valid=1 and
//     out_data=0x55 in the same cycle, count stays 0.
//  5. Flush with count=2 while in_valid=1 (0x99) -> in_ready=0 and out_valid=0
//     that cycle. Next cycle count=0, and 0x99 never appears at output.
//  6. PIPE_READY=1, DEPTH=1 full with 0x10: out_ready=1, in 0x20 -> pop 0x10 and
//     push 0x20 in the same cycle, count stays 1.
//     rst asserted mid-stream -> count=0 next cycle.

Source files
------------

// File: rtl/pipe_stage_fifo_pkg.sv
// Shared helpers for the pipe_stage_fifo decoupling buffer.
package pipe_stage_fifo_pkg;

  // Pointer width; a single-entry buffer still carries a 1-bit pointer held at zero.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Explicit wrap so non-power-of-two depths advance DEPTH-1 -> 0.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/pipe_stage_fifo_if.sv
// Valid/ready link through the buffer: producer side (in_*) and consumer side (out_*).
interface pipe_stage_fifo_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module pipe_fifo_mem
  import pipe_stage_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW   = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // Payload storage is deliberately left unreset; count gates visibility.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_stage_fifo.sv
// In-order DEPTH-entry decoupling queue for a valid/ready stage link, with optional
// empty bypass, optional ready-while-full-and-popping, and synchronous flush.
module pipe_stage_fifo
  import pipe_stage_fifo_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 2,
  parameter int BYPASS     = 0,
  parameter int PIPE_READY = 0,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  pipe_stage_fifo_if.slave link,
  output logic [CW-1:0] count
);

  localparam int AW = ptr_width(DEPTH);

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rdata;
  logic             empty, full, push, pop, wr_en, rd_adv;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  assign link.in_ready  = !flush && !rst &&
                          (!full || ((PIPE_READY != 0) && link.out_ready && full));
  assign link.out_valid = !flush && !rst &&
                          (!empty || ((BYPASS != 0) && link.in_valid));
  assign link.out_data  = ((BYPASS != 0) && empty) ? link.in_data : rdata;

  assign push   = link.in_valid && link.in_ready;
  assign pop    = link.out_valid && link.out_ready;
  // A pop while empty can only be a bypass pass-through: nothing is stored or read.
  assign rd_adv = pop && !empty;
  assign wr_en  = push && !(empty && pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = AW'(wrap_inc(32'(wr_ptr_q), DEPTH));
      end
      if (rd_adv) begin
        rd_ptr_d = AW'(wrap_inc(32'(rd_ptr_q), DEPTH));
      end
      case ({wr_en, rd_adv})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;

  pipe_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en && !flush),
    .waddr (wr_ptr_q),
    .wdata (link.in_data),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

endmodule
